// File: rtl/alu_decode_stage.sv
// RV32I decode stage: combinational decode of one instruction into ALU control and
// operands, registered behind a 2-entry skid buffer with a valid/ready handshake.
module alu_decode_stage #(
  parameter logic [3:0] ILLEGAL_CTRL = 4'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_ctrl,
  output logic [31:0] out_data1,
  output logic [31:0] out_data2,
  output logic        out_is_branch,
  output logic        out_illegal
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 4;

  localparam logic [CW-1:0] C_AND  = 4'd0;
  localparam logic [CW-1:0] C_OR   = 4'd1;
  localparam logic [CW-1:0] C_ADD  = 4'd2;
  localparam logic [CW-1:0] C_SUB  = 4'd3;
  localparam logic [CW-1:0] C_XOR  = 4'd4;
  localparam logic [CW-1:0] C_EQ   = 4'd5;
  localparam logic [CW-1:0] C_NE   = 4'd6;
  localparam logic [CW-1:0] C_SLT  = 4'd7;
  localparam logic [CW-1:0] C_SGE  = 4'd8;
  localparam logic [CW-1:0] C_SLTU = 4'd9;
  localparam logic [CW-1:0] C_SGEU = 4'd10;
  localparam logic [CW-1:0] C_SLL  = 4'd11;
  localparam logic [CW-1:0] C_SRL  = 4'd12;
  localparam logic [CW-1:0] C_SRA  = 4'd13;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u  = {in_instr[31:12], 12'd0};
  assign shamt  = XLEN'(in_instr[24:20]);

  logic [CW-1:0]   dec_ctrl;
  logic [XLEN-1:0] dec_d1;
  logic [XLEN-1:0] dec_d2;
  logic            dec_br;
  logic            dec_ill;

  // Instruction decode; any undecodable encoding collapses to the illegal form
  always_comb begin
    dec_ctrl = C_ADD;
    dec_d1   = in_rs1;
    dec_d2   = in_rs2;
    dec_br   = 1'b0;
    dec_ill  = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            3'b000:  dec_ctrl = C_ADD;
            3'b001:  dec_ctrl = C_SLL;
            3'b010:  dec_ctrl = C_SLT;
            3'b011:  dec_ctrl = C_SLTU;
            3'b100:  dec_ctrl = C_XOR;
            3'b101:  dec_ctrl = C_SRL;
            3'b110:  dec_ctrl = C_OR;
            default: dec_ctrl = C_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_ctrl = C_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_ctrl = C_SRA;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_d2 = imm_i;
        unique case (funct3)
          3'b000: dec_ctrl = C_ADD;
          3'b001: begin
            dec_ctrl = C_SLL;
            dec_d2   = shamt;
            dec_ill  = (funct7 != F7_BASE);
          end
          3'b010: dec_ctrl = C_SLT;
          3'b011: dec_ctrl = C_SLTU;
          3'b100: dec_ctrl = C_XOR;
          3'b101: begin
            dec_ctrl = (funct7 == F7_ALT) ? C_SRA : C_SRL;
            dec_d2   = shamt;
            dec_ill  = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
          3'b110:  dec_ctrl = C_OR;
          default: dec_ctrl = C_AND;
        endcase
      end
      OPC_BRANCH: begin
        dec_br = 1'b1;
        unique case (funct3)
          3'b000:  dec_ctrl = C_EQ;
          3'b001:  dec_ctrl = C_NE;
          3'b100:  dec_ctrl = C_SLT;
          3'b101:  dec_ctrl = C_SGE;
          3'b110:  dec_ctrl = C_SLTU;
          3'b111:  dec_ctrl = C_SGEU;
          default: dec_ill  = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_d1 = '0;
        dec_d2 = imm_u;
      end
      OPC_AUIPC: begin
        dec_d1 = in_pc;
        dec_d2 = imm_u;
      end
      OPC_LOAD:  dec_d2 = imm_i;
      OPC_STORE: dec_d2 = imm_s;
      OPC_JAL, OPC_JALR: begin
        dec_d1 = in_pc;
        dec_d2 = XLEN'(4);
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_ctrl = ILLEGAL_CTRL;
      dec_d1   = '0;
      dec_d2   = '0;
      dec_br   = 1'b0;
    end
  end

  logic            main_vld_q, main_vld_d;
  logic [CW-1:0]   main_ctrl_q, main_ctrl_d;
  logic [XLEN-1:0] main_d1_q, main_d1_d;
  logic [XLEN-1:0] main_d2_q, main_d2_d;
  logic            main_br_q, main_br_d;
  logic            main_ill_q, main_ill_d;
  logic            skid_vld_q, skid_vld_d;
  logic [CW-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [XLEN-1:0] skid_d1_q, skid_d1_d;
  logic [XLEN-1:0] skid_d2_q, skid_d2_d;
  logic            skid_br_q, skid_br_d;
  logic            skid_ill_q, skid_ill_d;
  logic            ready_q, ready_d;
  logic            in_xfer;
  logic            out_xfer;

  assign in_xfer  = in_valid & ready_q;
  assign out_xfer = main_vld_q & out_ready;

  // Skid-buffer next state: main is the output register, skid absorbs one stalled input
  always_comb begin
    main_vld_d  = main_vld_q;
    main_ctrl_d = main_ctrl_q;
    main_d1_d   = main_d1_q;
    main_d2_d   = main_d2_q;
    main_br_d   = main_br_q;
    main_ill_d  = main_ill_q;
    skid_vld_d  = skid_vld_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_d1_d   = skid_d1_q;
    skid_d2_d   = skid_d2_q;
    skid_br_d   = skid_br_q;
    skid_ill_d  = skid_ill_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      if (out_xfer) begin
        main_ctrl_d = skid_ctrl_q;
        main_d1_d   = skid_d1_q;
        main_d2_d   = skid_d2_q;
        main_br_d   = skid_br_q;
        main_ill_d  = skid_ill_q;
        skid_vld_d  = 1'b0;
      end
    end else if (in_xfer && (!main_vld_q || out_xfer)) begin
      main_vld_d  = 1'b1;
      main_ctrl_d = dec_ctrl;
      main_d1_d   = dec_d1;
      main_d2_d   = dec_d2;
      main_br_d   = dec_br;
      main_ill_d  = dec_ill;
    end else if (in_xfer) begin
      skid_vld_d  = 1'b1;
      skid_ctrl_d = dec_ctrl;
      skid_d1_d   = dec_d1;
      skid_d2_d   = dec_d2;
      skid_br_d   = dec_br;
      skid_ill_d  = dec_ill;
    end else if (out_xfer) begin
      main_vld_d = 1'b0;
    end
    ready_d = ~skid_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_d1_q   <= '0;
      main_d2_q   <= '0;
      main_br_q   <= 1'b0;
      main_ill_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_ctrl_q <= '0;
      skid_d1_q   <= '0;
      skid_d2_q   <= '0;
      skid_br_q   <= 1'b0;
      skid_ill_q  <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      main_vld_q  <= main_vld_d;
      main_ctrl_q <= main_ctrl_d;
      main_d1_q   <= main_d1_d;
      main_d2_q   <= main_d2_d;
      main_br_q   <= main_br_d;
      main_ill_q  <= main_ill_d;
      skid_vld_q  <= skid_vld_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_d1_q   <= skid_d1_d;
      skid_d2_q   <= skid_d2_d;
      skid_br_q   <= skid_br_d;
      skid_ill_q  <= skid_ill_d;
      ready_q     <= ready_d;
    end
  end

  assign in_ready      = ready_q;
  assign out_valid     = main_vld_q;
  assign out_ctrl      = main_ctrl_q;
  assign out_data1     = main_d1_q;
  assign out_data2     = main_d2_q;
  assign out_is_branch = main_br_q;
  assign out_illegal   = main_ill_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: table of decode vectors plus handshake,
// skid, flush and reset sequences with hand-computed expectations.
module tb_alu_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_ctrl;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic        out_is_branch;
  logic        out_illegal;

  int checks;
  int errors;

  alu_decode_stage #(.ILLEGAL_CTRL(4'd15)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data1(out_data1), .out_data2(out_data2),
    .out_is_branch(out_is_branch), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        br;
    logic        ill;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] rs1);
    in_valid = v;
    in_instr = instr;
    in_pc    = 32'h0;
    in_rs1   = rs1;
    in_rs2   = 32'h0;
  endtask

  localparam logic [31:0] ADD_I = 32'h002081B3;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);

    vecs[0]  = '{"add",    32'h002081B3, 32'h0,   32'd5,        32'd7, 4'd2,  32'd5,        32'd7,        1'b0, 1'b0};
    vecs[1]  = '{"sub",    32'h402081B3, 32'h0,   32'd10,       32'd3, 4'd3,  32'd10,       32'd3,        1'b0, 1'b0};
    vecs[2]  = '{"srai",   32'h4040D093, 32'h0,   32'h80000000, 32'd9, 4'd13, 32'h80000000, 32'd4,        1'b0, 1'b0};
    vecs[3]  = '{"bgeu",   32'h0020F063, 32'h0,   32'd11,       32'd2, 4'd10, 32'd11,       32'd2,        1'b1, 1'b0};
    vecs[4]  = '{"addi",   32'hFFF00093, 32'h0,   32'd1,        32'd0, 4'd2,  32'd1,        32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[5]  = '{"auipc",  32'h12345097, 32'h100, 32'd3,        32'd0, 4'd2,  32'h100,      32'h12345000, 1'b0, 1'b0};
    vecs[6]  = '{"lui",    32'h12345037, 32'h100, 32'd3,        32'd0, 4'd2,  32'h0,        32'h12345000, 1'b0, 1'b0};
    vecs[7]  = '{"opc7f",  32'h0000007F, 32'h40,  32'd3,        32'd4, 4'd15, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[8]  = '{"f7_01",  32'h022081B3, 32'h0,   32'd3,        32'd4, 4'd15, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[9]  = '{"sw",     32'hFE20AE23, 32'h0,   32'h1000,     32'd4, 4'd2,  32'h1000,     32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[10] = '{"lw",     32'h00812083, 32'h0,   32'h2000,     32'd4, 4'd2,  32'h2000,     32'd8,        1'b0, 1'b0};
    vecs[11] = '{"jal",    32'h0000006F, 32'h200, 32'd3,        32'd4, 4'd2,  32'h200,      32'd4,        1'b0, 1'b0};
    vecs[12] = '{"br010",  32'h00002063, 32'h0,   32'd3,        32'd4, 4'd15, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[13] = '{"slli20", 32'h40009093, 32'h0,   32'd3,        32'd4, 4'd15, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[14] = '{"xori",   32'h0F00C093, 32'h0,   32'hFF,       32'd4, 4'd4,  32'hFF,       32'hF0,       1'b0, 1'b0};
    vecs[15] = '{"blt",    32'h0020C063, 32'h0,   32'd6,        32'd8, 4'd7,  32'd6,        32'd8,        1'b1, 1'b0};
    vecs[16] = '{"srl",    32'h0020D1B3, 32'h0,   32'd6,        32'd8, 4'd12, 32'd6,        32'd8,        1'b0, 1'b0};
    vecs[17] = '{"sltu",   32'h0020B1B3, 32'h0,   32'd6,        32'd8, 4'd9,  32'd6,        32'd8,        1'b0, 1'b0};

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_ctrl",      32'(out_ctrl),  32'd0);
    check("rst_data1",     out_data1,      32'd0);
    check("rst_data2",     out_data2,      32'd0);
    check("rst_br",        32'(out_is_branch), 32'd0);
    check("rst_ill",       32'(out_illegal),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Decode table, one entry per cycle with out_ready high
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = vecs[i].pc;
      in_rs1   = vecs[i].rs1;
      in_rs2   = vecs[i].rs2;
      step();
      in_valid = 1'b0;
      check({vecs[i].name, "_valid"}, 32'(out_valid),     32'd1);
      check({vecs[i].name, "_ctrl"},  32'(out_ctrl),      32'(vecs[i].ctrl));
      check({vecs[i].name, "_d1"},    out_data1,          vecs[i].d1);
      check({vecs[i].name, "_d2"},    out_data2,          vecs[i].d2);
      check({vecs[i].name, "_br"},    32'(out_is_branch), 32'(vecs[i].br));
      check({vecs[i].name, "_ill"},   32'(out_illegal),   32'(vecs[i].ill));
    end
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Back-to-back stream: one entry per cycle, main replaced in place
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ADD_I, 32'(100 + i));
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_ready", 32'(in_ready),  32'd1);
      check("stream_d1",    out_data1,      32'(100 + i));
    end
    drive(1'b0, ADD_I, 32'd0);
    step();
    check("stream_end_valid", 32'(out_valid), 32'd0);

    // Stall: three offered, two accepted, drained in order
    out_ready = 1'b0;
    drive(1'b1, ADD_I, 32'hA);
    step();
    check("stall_a_ready", 32'(in_ready),  32'd1);
    check("stall_a_d1",    out_data1,      32'hA);
    drive(1'b1, ADD_I, 32'hB);
    step();
    check("stall_b_ready", 32'(in_ready),  32'd0);
    check("stall_b_hold",  out_data1,      32'hA);
    drive(1'b1, ADD_I, 32'hC);
    step();
    check("stall_c_ready", 32'(in_ready),  32'd0);
    check("stall_c_hold",  out_data1,      32'hA);
    check("stall_c_valid", 32'(out_valid), 32'd1);
    drive(1'b0, ADD_I, 32'h0);
    out_ready = 1'b1;
    step();
    check("drain_b_valid", 32'(out_valid), 32'd1);
    check("drain_b_d1",    out_data1,      32'hB);
    check("drain_b_ready", 32'(in_ready),  32'd1);
    step();
    check("drain_empty",   32'(out_valid), 32'd0);

    // Flush with skid full and an input offered
    out_ready = 1'b0;
    drive(1'b1, ADD_I, 32'h1);
    step();
    drive(1'b1, ADD_I, 32'h2);
    step();
    check("fl_pre_ready", 32'(in_ready), 32'd0);
    drive(1'b1, ADD_I, 32'h3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, ADD_I, 32'h0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    step();
    check("fl_none1", 32'(out_valid), 32'd0);
    step();
    check("fl_none2", 32'(out_valid), 32'd0);

    // Flush dominates an input that would otherwise be accepted
    drive(1'b1, ADD_I, 32'h4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, ADD_I, 32'h0);
    check("fl_in_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-transfer drops everything at once
    out_ready = 1'b0;
    drive(1'b1, ADD_I, 32'h5);
    step();
    drive(1'b1, ADD_I, 32'h6);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready),  32'd1);
    check("ar_ctrl",  32'(out_ctrl),  32'd0);
    check("ar_d1",    out_data1,      32'd0);
    drive(1'b0, ADD_I, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, ADD_I, 32'h7);
    step();
    drive(1'b0, ADD_I, 32'h0);
    check("ar_first_valid", 32'(out_valid), 32'd1);
    check("ar_first_d1",    out_data1,      32'h7);
    step();
    check("ar_end", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
